// File: rtl/machine_demultiplex.sv
// Lane-serial to word demultiplexer: rebuilds LANES beats (lane 0 first, framed by din_first)
// into one word behind a valid/ready output register. Optional parity: MACHINE_DEMUX_PARITY_EN.
module machine_demultiplex #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                      system1000,
    input  logic                      system1000_rst,
    input  logic [LANE_W-1:0]         din,
    input  logic                      din_valid,
    input  logic                      din_first,
`ifdef MACHINE_DEMUX_PARITY_EN
    input  logic                      din_par,
    output logic                      dout_par_err,
`endif
    output logic [LANES*LANE_W-1:0]   dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      sync_err,
    output logic                      overrun
);

    localparam int W     = LANES * LANE_W;
    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic {IDLE, COLLECT} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     asm_q, asm_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             sync_err_q, sync_err_d;
    logic             overrun_q, overrun_d;
    logic             complete;

`ifdef MACHINE_DEMUX_PARITY_EN
    logic par_q, par_d;
    logic dout_par_q, dout_par_d;
    logic beat_bad;
    logic word_par;

    assign beat_bad = din_valid & ((^din) ^ din_par);
    assign word_par = par_q | beat_bad;
`endif

    // State register: every flop in the block, cleared asynchronously.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef MACHINE_DEMUX_PARITY_EN
            par_q        <= 1'b0;
            dout_par_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking here so every flop samples the pre-edge values of the others.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
            overrun_q    <= overrun_d;
`ifdef MACHINE_DEMUX_PARITY_EN
            par_q        <= par_d;
            dout_par_q   <= dout_par_d;
`endif
        end
    end

    // Next-state logic: framing, lane counter and assembly register.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        asm_d      = asm_q;
        complete   = 1'b0;
        sync_err_d = 1'b0;
`ifdef MACHINE_DEMUX_PARITY_EN
        par_d      = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    if (din_first) begin
                        asm_d[LANE_W-1:0] = din;
                        cnt_d             = CNT_W'(1);
                        state_d           = COLLECT;
`ifdef MACHINE_DEMUX_PARITY_EN
                        par_d             = beat_bad;
`endif
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (din_valid) begin
                    if (din_first) begin
                        sync_err_d        = 1'b1;
                        asm_d[LANE_W-1:0] = din;
                        cnt_d             = CNT_W'(1);
`ifdef MACHINE_DEMUX_PARITY_EN
                        par_d             = beat_bad;
`endif
                    end else begin
                        asm_d[int'(cnt_q)*LANE_W +: LANE_W] = din;
`ifdef MACHINE_DEMUX_PARITY_EN
                        par_d = word_par;
`endif
                        if (cnt_q == LAST_LANE) begin
                            complete = 1'b1;
                            cnt_d    = '0;
                            state_d  = IDLE;
`ifdef MACHINE_DEMUX_PARITY_EN
                            par_d    = 1'b0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a completed word only replaces dout when the slot is free or being consumed.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;
`ifdef MACHINE_DEMUX_PARITY_EN
        dout_par_d   = dout_par_q;
`endif
        if (complete) begin
            if (!dout_valid_q || dout_ready) begin
                dout_d       = asm_d;
                dout_valid_d = 1'b1;
`ifdef MACHINE_DEMUX_PARITY_EN
                dout_par_d   = word_par;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sync_err   = sync_err_q;
    assign overrun    = overrun_q;
`ifdef MACHINE_DEMUX_PARITY_EN
    assign dout_par_err = dout_par_q;
`endif

endmodule

// File: tb/tb_machine_demultiplex.sv
// Directed testbench for machine_demultiplex (LANE_W=4, LANES=4); parity checks
// run only when MACHINE_DEMUX_PARITY_EN is defined.
module tb_machine_demultiplex;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic        din_valid;
    logic        din_first;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        sync_err;
    logic        overrun;
`ifdef MACHINE_DEMUX_PARITY_EN
    logic        din_par;
    logic        dout_par_err;
    logic        bad_par;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    machine_demultiplex #(.LANE_W(4), .LANES(4)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .din            (din),
        .din_valid      (din_valid),
        .din_first      (din_first),
`ifdef MACHINE_DEMUX_PARITY_EN
        .din_par        (din_par),
        .dout_par_err   (dout_par_err),
`endif
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .sync_err       (sync_err),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input, then return 1 time unit after the sampling edge.
    task automatic step(input logic [3:0] d, input logic v, input logic f);
        din       = d;
        din_valid = v;
        din_first = f;
`ifdef MACHINE_DEMUX_PARITY_EN
        din_par   = (^d) ^ bad_par;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        dout_ready = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        din_first  = 1'b0;
`ifdef MACHINE_DEMUX_PARITY_EN
        bad_par    = 1'b0;
        din_par    = 1'b0;
`endif
        @(posedge clk);
        #1;
        tests_run++;
        if (dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout got %h exp 0000", dout); end
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        tests_run++;
        if (sync_err !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++; $display("FAIL reset_pulses got sync=%b ovr=%b exp 0 0", sync_err, overrun);
        end
`ifdef MACHINE_DEMUX_PARITY_EN
        tests_run++;
        if (dout_par_err !== 1'b0) begin tests_failed++; $display("FAIL reset_par got %b exp 0", dout_par_err); end
`endif
        rst = 1'b0;
        step(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_basic_word();
        dout_ready = 1'b1;
        step(4'hF, 1'b1, 1'b1);
        step(4'hE, 1'b1, 1'b0);
        step(4'hE, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid got %b exp 0", dout_valid); end
        step(4'hB, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
        tests_run++;
        if (dout !== 16'hBEEF) begin tests_failed++; $display("FAIL basic_dout got %h exp BEEF", dout); end
        tests_run++;
        if (sync_err !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++; $display("FAIL basic_pulses got sync=%b ovr=%b exp 0 0", sync_err, overrun);
        end
        step(4'h0, 1'b0, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_consumed got %b exp 0", dout_valid); end
        tests_run++;
        if (dout !== 16'hBEEF) begin tests_failed++; $display("FAIL basic_hold got %h exp BEEF", dout); end
    endtask

    task automatic test_sync_idle();
        dout_ready = 1'b1;
        step(4'h3, 1'b1, 1'b0);
        tests_run++;
        if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL idle_sync_pulse got %b exp 1", sync_err); end
        step(4'h4, 1'b1, 1'b1);
        tests_run++;
        if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL idle_sync_once got %b exp 0", sync_err); end
        step(4'h3, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 16'h1234) begin
            tests_failed++; $display("FAIL idle_word got valid=%b dout=%h exp 1 1234", dout_valid, dout);
        end
        step(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_restart();
        dout_ready = 1'b1;
        step(4'hA, 1'b1, 1'b1);
        step(4'hB, 1'b1, 1'b0);
        tests_run++;
        if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL restart_pre got %b exp 0", sync_err); end
        step(4'h5, 1'b1, 1'b1);
        tests_run++;
        if (sync_err !== 1'b1) begin tests_failed++; $display("FAIL restart_pulse got %b exp 1", sync_err); end
        step(4'h6, 1'b1, 1'b0);
        tests_run++;
        if (sync_err !== 1'b0) begin tests_failed++; $display("FAIL restart_once got %b exp 0", sync_err); end
        step(4'h7, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL restart_early got %b exp 0", dout_valid); end
        step(4'h8, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 16'h8765) begin
            tests_failed++; $display("FAIL restart_word got valid=%b dout=%h exp 1 8765", dout_valid, dout);
        end
        step(4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        dout_ready = 1'b0;
        step(4'hA, 1'b1, 1'b1);
        step(4'hA, 1'b1, 1'b0);
        step(4'hA, 1'b1, 1'b0);
        step(4'hA, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 16'hAAAA) begin
            tests_failed++; $display("FAIL ovr_first got valid=%b dout=%h exp 1 AAAA", dout_valid, dout);
        end
        step(4'h5, 1'b1, 1'b1);
        step(4'h5, 1'b1, 1'b0);
        step(4'h5, 1'b1, 1'b0);
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_early got %b exp 0", overrun); end
        step(4'h5, 1'b1, 1'b0);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
        tests_run++;
        if (dout !== 16'hAAAA || dout_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ovr_keep got valid=%b dout=%h exp 1 AAAA", dout_valid, dout);
        end
        step(4'h0, 1'b0, 1'b0);
        tests_run++;
        if (overrun !== 1'b0 || dout !== 16'hAAAA) begin
            tests_failed++; $display("FAIL ovr_once got ovr=%b dout=%h exp 0 AAAA", overrun, dout);
        end
        dout_ready = 1'b1;
        step(4'h0, 1'b0, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_drain got %b exp 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        words[0] = 16'h0001;
        words[1] = 16'h0002;
        words[2] = 16'h0003;
        dout_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 4; b++) begin
                step(words[w][b*4 +: 4], 1'b1, (b == 0));
                if (b == 1 || b == 2) begin
                    tests_run++;
                    if (dout_valid !== 1'b0) begin
                        tests_failed++; $display("FAIL b2b_gap%0d_%0d got %b exp 0", w, b, dout_valid);
                    end
                end
            end
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== words[w] || overrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_word%0d got valid=%b dout=%h ovr=%b exp 1 %h 0", w, dout_valid, dout, overrun, words[w]);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        dout_ready = 1'b0;
        step(4'h1, 1'b1, 1'b1);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b1);
        step(4'h0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        tests_run++;
        if (dout !== 16'h0000 || dout_valid !== 1'b0 || sync_err !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs got dout=%h v=%b s=%b o=%b exp 0000 0 0 0", dout, dout_valid, sync_err, overrun);
        end
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dout_ready = 1'b1;
        step(4'h3, 1'b1, 1'b1);
        step(4'hC, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        step(4'h0, 1'b1, 1'b0);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 16'h00C3 || sync_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_word got valid=%b dout=%h sync=%b exp 1 00C3 0", dout_valid, dout, sync_err);
        end
        step(4'h0, 1'b0, 1'b0);
    endtask

`ifdef MACHINE_DEMUX_PARITY_EN
    task automatic test_parity();
        dout_ready = 1'b1;
        bad_par = 1'b0; step(4'hF, 1'b1, 1'b1);
        bad_par = 1'b0; step(4'hE, 1'b1, 1'b0);
        bad_par = 1'b1; step(4'hE, 1'b1, 1'b0);
        bad_par = 1'b0; step(4'hB, 1'b1, 1'b0);
        tests_run++;
        if (dout !== 16'hBEEF || dout_par_err !== 1'b1) begin
            tests_failed++; $display("FAIL par_bad got dout=%h perr=%b exp BEEF 1", dout, dout_par_err);
        end
        step(4'h4, 1'b1, 1'b1);
        step(4'h3, 1'b1, 1'b0);
        step(4'h2, 1'b1, 1'b0);
        step(4'h1, 1'b1, 1'b0);
        tests_run++;
        if (dout !== 16'h1234 || dout_par_err !== 1'b0) begin
            tests_failed++; $display("FAIL par_clean got dout=%h perr=%b exp 1234 0", dout, dout_par_err);
        end
        step(4'h0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_word();
        test_sync_idle();
        test_restart();
        test_overrun();
        test_back_to_back();
        test_reset_mid_word();
`ifdef MACHINE_DEMUX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
